// File: rtl/pwm_pkg.sv
// Shared defaults and the ramp helper for the multi-channel PWM generator.
package pwm_pkg;

  localparam int PWM_WIDTH_DEFAULT    = 8;
  localparam int PWM_CHANNELS_DEFAULT = 4;
  localparam int PWM_RAMP_DEFAULT     = 1;
  localparam int PWM_FN_W             = 32;

  // Next active duty: step toward tgt by at most step, landing exactly on tgt.
  // step == 0 means jump straight to the target.
  function automatic logic [PWM_FN_W-1:0] ramp_step(
    input logic [PWM_FN_W-1:0] act,
    input logic [PWM_FN_W-1:0] tgt,
    input logic [PWM_FN_W-1:0] step
  );
    logic [PWM_FN_W-1:0] diff;
    if (step == '0) begin
      return tgt;
    end
    if (act < tgt) begin
      diff = tgt - act;
      return (diff > step) ? act + step : tgt;
    end
    diff = act - tgt;
    return (diff > step) ? act - step : tgt;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty target, soft-start ramp applied at
// period wraps, and the registered duty compare.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH     = PWM_WIDTH_DEFAULT,
  parameter int RAMP_STEP = PWM_RAMP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             wrap,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty_in,
  output logic             pwm
);

  logic [WIDTH-1:0] tgt_reg;
  logic [WIDTH-1:0] act_reg;
  logic [WIDTH-1:0] act_next;

  always_comb begin
    act_next = WIDTH'(ramp_step(PWM_FN_W'(act_reg), PWM_FN_W'(tgt_reg),
                                PWM_FN_W'(RAMP_STEP)));
  end

  // A wrap coinciding with load still ramps toward the pre-edge target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_reg <= '0;
      act_reg <= '0;
      pwm     <= 1'b0;
    end else begin
      if (load) begin
        tgt_reg <= duty_in;
      end
      if (!en) begin
        act_reg <= '0;
      end else if (wrap) begin
        act_reg <= act_next;
      end
      pwm <= en & (cnt < act_reg);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared period counter with double-buffered period,
// feeding CHANNELS independent ramped duty comparators.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH     = PWM_WIDTH_DEFAULT,
  parameter int CHANNELS  = PWM_CHANNELS_DEFAULT,
  parameter int RAMP_STEP = PWM_RAMP_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start
);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] per_tgt_reg;
  logic [WIDTH-1:0] per_act_reg;
  logic             wrap;

  assign wrap = en & (cnt_reg == per_act_reg);

  // Period changes only land at a wrap, so no runt period is ever produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      per_tgt_reg  <= '1;
      per_act_reg  <= '1;
      period_start <= 1'b0;
    end else begin
      if (load) begin
        per_tgt_reg <= period;
      end
      if (!en) begin
        cnt_reg <= '0;
      end else if (wrap) begin
        cnt_reg     <= '0;
        per_act_reg <= per_tgt_reg;
      end else begin
        cnt_reg <= cnt_reg + WIDTH'(1);
      end
      period_start <= en & (cnt_reg == '0);
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      pwm_channel #(
        .WIDTH     (WIDTH),
        .RAMP_STEP (RAMP_STEP)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .wrap    (wrap),
        .cnt     (cnt_reg),
        .duty_in (duty[gi*WIDTH +: WIDTH]),
        .pwm     (pwm_out[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench: stimulus queues expected per-period widths and snapshots,
// a negedge monitor measures periods between period_start pulses and compares.
module tb_pwm_multi;

  localparam int W  = 8;
  localparam int CH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              load;
  logic [W-1:0]      period;
  logic [CH*W-1:0]   duty;
  logic [CH-1:0]     pwm_o [3];
  logic [2:0]        ps_o;
  int                sel;
  logic [CH-1:0]     pwm_cur;
  logic              ps_cur;

  // Instance 0: RAMP_STEP=0, instance 1: RAMP_STEP=2, instance 2: RAMP_STEP=1.
  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .RAMP_STEP(0)) dut_r0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .period(period), .duty(duty),
    .pwm_out(pwm_o[0]), .period_start(ps_o[0]));
  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .RAMP_STEP(2)) dut_r2 (
    .clk(clk), .rst(rst), .en(en), .load(load), .period(period), .duty(duty),
    .pwm_out(pwm_o[1]), .period_start(ps_o[1]));
  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .RAMP_STEP(1)) dut_r1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .period(period), .duty(duty),
    .pwm_out(pwm_o[2]), .period_start(ps_o[2]));

  assign pwm_cur = pwm_o[sel];
  assign ps_cur  = ps_o[sel];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int                  t;
    int                  len;
    logic [CH-1:0][15:0] w;
  } per_exp_t;

  typedef struct packed {
    int            t;
    logic          is_to;
    logic [CH-1:0] pwm;
    logic          ps;
  } snap_t;

  per_exp_t per_q[$];
  snap_t    snap_q[$];
  int       total = 0;
  int       bad   = 0;

  // Monitor
  initial begin : mon
    logic     win_open;
    int       win_start;
    int       win_len;
    int       win_w [CH];
    snap_t    s;
    per_exp_t e;
    win_open = 1'b0;
    win_start = 0;
    win_len = 0;
    for (int c = 0; c < CH; c++) win_w[c] = 0;
    forever begin
      @(negedge clk);
      while (snap_q.size() > 0 && snap_q[0].t <= cyc) begin
        s = snap_q.pop_front();
        total++;
        if (s.is_to) begin
          bad++;
          $display("FAIL timeout: waited too long for DUT at cycle %0d", cyc);
        end else if (s.t != cyc) begin
          bad++;
          $display("FAIL snap_late: due cycle %0d seen at %0d", s.t, cyc);
        end else if (pwm_cur !== s.pwm || ps_cur !== s.ps) begin
          bad++;
          $display("FAIL snap cyc=%0d: pwm=%b ps=%b required pwm=%b ps=%b",
                   cyc, pwm_cur, ps_cur, s.pwm, s.ps);
        end else begin
          $display("snap cyc=%0d pwm=%b ps=%b ok", cyc, pwm_cur, ps_cur);
        end
      end
      if (rst || !en) begin
        win_open = 1'b0;
      end else if (ps_cur) begin
        if (win_open && per_q.size() > 0 && per_q[0].t < win_start) begin
          e = per_q.pop_front();
          total++;
          if (win_len != e.len) begin
            bad++;
            $display("FAIL period_len start=%0d: got %0d required %0d",
                     win_start, win_len, e.len);
          end
          for (int c = 0; c < CH; c++) begin
            total++;
            if (win_w[c] != int'(e.w[c])) begin
              bad++;
              $display("FAIL width ch%0d start=%0d: got %0d required %0d",
                       c, win_start, win_w[c], e.w[c]);
            end
          end
          $display("period start=%0d len=%0d widths=%0d,%0d,%0d,%0d",
                   win_start, win_len, win_w[0], win_w[1], win_w[2], win_w[3]);
        end
        win_open  = 1'b1;
        win_start = cyc;
        win_len   = 1;
        for (int c = 0; c < CH; c++) win_w[c] = int'(pwm_cur[c]);
      end else if (win_open) begin
        win_len++;
        for (int c = 0; c < CH; c++) win_w[c] += int'(pwm_cur[c]);
      end
    end
  end

  task automatic push_per(input int len, input int w0, input int w1,
                          input int w2, input int w3);
    per_exp_t r;
    r.t    = cyc;
    r.len  = len;
    r.w[0] = 16'(w0);
    r.w[1] = 16'(w1);
    r.w[2] = 16'(w2);
    r.w[3] = 16'(w3);
    per_q.push_back(r);
  endtask

  task automatic push_snap(input logic [CH-1:0] p, input logic s);
    snap_t r;
    r.t     = cyc;
    r.is_to = 1'b0;
    r.pwm   = p;
    r.ps    = s;
    snap_q.push_back(r);
  endtask

  task automatic push_to();
    snap_t r;
    r.t     = cyc;
    r.is_to = 1'b1;
    r.pwm   = '0;
    r.ps    = 1'b0;
    snap_q.push_back(r);
  endtask

  task automatic wait_ps();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ps_cur) return;
    end
    push_to();
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && per_q.size() != 0; i++) @(negedge clk);
    if (per_q.size() != 0) begin
      push_to();
      per_q.delete();
    end
  endtask

  task automatic load_cfg(input logic [W-1:0] p, input logic [CH*W-1:0] d);
    @(posedge clk); #1;
    period = p;
    duty   = d;
    load   = 1'b1;
    @(posedge clk); #1;
    load   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; period = '0; duty = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    push_snap(4'b0000, 1'b0);

    // Jump-to-target channels, period 9; first period runs at reset period 255.
    load_cfg(8'd9, {8'd0, 8'd5, 8'd10, 8'd3});
    en = 1'b1;
    push_per(256, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) push_per(10, 3, 10, 5, 0);
    drain();

    // Ramp by 2 up to 7, then down to 1.
    @(posedge clk); #1 en = 1'b0; sel = 1;
    load_cfg(8'd9, {24'd0, 8'd7});
    en = 1'b1;
    push_per(10, 0, 0, 0, 0);
    push_per(10, 2, 0, 0, 0);
    push_per(10, 4, 0, 0, 0);
    push_per(10, 6, 0, 0, 0);
    push_per(10, 7, 0, 0, 0);
    push_per(10, 7, 0, 0, 0);
    drain();
    load_cfg(8'd9, {24'd0, 8'd1});
    push_per(10, 5, 0, 0, 0);
    push_per(10, 3, 0, 0, 0);
    push_per(10, 1, 0, 0, 0);
    push_per(10, 1, 0, 0, 0);
    drain();

    // Period 4 loaded on the very edge that wraps period 9.
    wait_ps();
    repeat (8) @(posedge clk);
    #1 period = 8'd4; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    push_per(10, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) push_per(5, 1, 0, 0, 0);
    drain();

    // Ramp by 1 to 6 (first period still uses the old period 4), then en drop.
    @(posedge clk); #1 en = 1'b0; sel = 2;
    load_cfg(8'd9, {24'd0, 8'd6});
    en = 1'b1;
    push_per(5, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) push_per(10, k, 0, 0, 0);
    drain();
    wait_ps();
    repeat (3) @(posedge clk);
    #1 push_snap(4'b0001, 1'b0);
    en = 1'b0;
    @(posedge clk); #1 push_snap(4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1 en = 1'b1;
    push_per(10, 0, 0, 0, 0);
    push_per(10, 1, 0, 0, 0);
    push_per(10, 2, 0, 0, 0);
    drain();

    // Asynchronous reset mid-period.
    wait_ps();
    @(posedge clk); #1 push_snap(4'b0001, 1'b0);
    @(posedge clk); #2 rst = 1'b1;
    push_snap(4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_per(256, 0, 0, 0, 0);
    drain();

    // Period 0: every cycle is a wrap.
    @(posedge clk); #1 en = 1'b0;
    load_cfg(8'd0, {4{8'd1}});
    en = 1'b1;
    push_per(256, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) push_per(1, 1, 1, 1, 1);
    drain();
    @(posedge clk); #1 push_snap(4'b1111, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
